// File: rtl/dmux8way16_buf.sv
// Buffered 1-to-8 demultiplexer: one valid/ready input word is routed by in_sel
// into a one-entry register per output channel, each with its own valid/ready.
module dmux8way16_buf #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [2:0]         in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [8*WIDTH-1:0] out_data,
    output logic [7:0]         out_valid,
    input  logic [7:0]         out_ready,
    output logic [15:0]        accept_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_t;

    chan_state_t      state     [8];
    logic [WIDTH-1:0] chan_data [8];
    logic             accept;

    // A full channel can still take a word if its consumer drains it this cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        in_ready = 1'b0;
        accept   = 1'b0;
        in_ready = (state[in_sel] == EMPTY) || out_ready[in_sel];
        accept   = in_valid && in_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 8; k++) begin
                state[k]     <= EMPTY;
                // NOTE: the data registers are reset as well, because channels must read 0 after reset.
                chan_data[k] <= '0;
            end
            accept_count <= '0;
        end else begin
            // NOTE: non-blocking assignments so every channel sees the pre-edge state.
            for (int k = 0; k < 8; k++) begin
                if (accept && (in_sel == 3'(k))) begin
                    state[k]     <= FULL;
                    chan_data[k] <= in_data;
                end else if (out_ready[k]) begin
                    state[k] <= EMPTY;
                end
            end
            if (accept) begin
                accept_count <= accept_count + 16'd1;
            end
        end
    end

    for (genvar g = 0; g < 8; g++) begin : g_chan
        assign out_valid[g]                  = (state[g] == FULL);
        assign out_data[WIDTH*g +: WIDTH]    = chan_data[g];
    end

endmodule

// File: tb/tb_dmux8way16_buf.sv
// Scoreboard bench for dmux8way16_buf: stimulus pushes expected words per channel,
// a negedge monitor pops and compares on every delivery (out_valid && out_ready).
module tb_dmux8way16_buf;

    logic         clk = 1'b0;
    logic         reset;
    logic [15:0]  in_data;
    logic [2:0]   in_sel;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] out_data;
    logic [7:0]   out_valid;
    logic [7:0]   out_ready;
    logic [15:0]  accept_count;

    int          n_vec  = 0;
    int          n_fail = 0;
    int          cycles = 0;
    logic [15:0] exp_count = '0;
    logic [15:0] exp_q [8][$];

    dmux8way16_buf #(.WIDTH(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_sel       (in_sel),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .accept_count (accept_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycles <= cycles + 1;

    function automatic logic [15:0] chan(input int k);
        return out_data[16*k +: 16];
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a delivery happens at the next edge when out_valid[k] && out_ready[k].
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            for (int k = 0; k < 8; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    if (exp_q[k].size() == 0) begin
                        n_vec++;
                        n_fail++;
                        $display("FAIL spurious delivery ch%0d: got %0h, expected none", k, chan(k));
                    end else begin
                        check($sformatf("deliver ch%0d", k), {112'd0, chan(k)}, {112'd0, exp_q[k].pop_front()});
                    end
                end
            end
        end
    end

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("in_ready during reset", {127'd0, in_ready}, 128'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 8; k++) exp_q[k].delete();
        exp_count = '0;
    endtask

    task automatic check_reset_state();
        check("reset out_valid", {120'd0, out_valid}, 128'd0);
        check("reset out_data", out_data, 128'd0);
        check("reset accept_count", {112'd0, accept_count}, 128'd0);
    endtask

    // Issues one word and holds it until accepted (bounded wait).
    task automatic send(input logic [2:0] sel, input logic [15:0] data);
        int budget;
        in_sel   = sel;
        in_data  = data;
        in_valid = 1'b1;
        exp_q[sel].push_back(data);
        budget = 0;
        @(negedge clk);
        while (!in_ready && budget < 20) begin
            budget++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_vec++;
            n_fail++;
            $display("FAIL send timeout sel=%0d: got in_ready=0, expected 1", sel);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        exp_count = exp_count + 16'd1;
    endtask

    initial begin
        int start;
        in_data   = '0;
        in_sel    = '0;
        in_valid  = 1'b0;
        out_ready = '0;

        // 1. reset
        do_reset();
        check_reset_state();
        check("idle in_ready", {127'd0, in_ready}, 128'd1);

        // 2. single word to channel 5, then held
        send(3'd5, 16'hBEEF);
        check("t2 out_valid", {120'd0, out_valid}, 128'h20);
        check("t2 out_data", out_data, {32'd0, 16'hBEEF, 80'd0});
        check("t2 accept_count", {112'd0, accept_count}, 128'd1);
        repeat (3) @(posedge clk);
        #1;
        check("t2 hold out_valid", {120'd0, out_valid}, 128'h20);
        check("t2 hold ch5", {112'd0, chan(5)}, 128'hBEEF);

        // 3. blocked on full channel, released by same-cycle drain
        in_sel   = 3'd5;
        in_data  = 16'h1234;
        in_valid = 1'b1;
        exp_q[5].push_back(16'h1234);
        @(negedge clk);
        check("t3 blocked in_ready", {127'd0, in_ready}, 128'd0);
        @(posedge clk);
        #1;
        check("t3 no change ch5", {112'd0, chan(5)}, 128'hBEEF);
        check("t3 no change count", {112'd0, accept_count}, 128'd1);
        out_ready[5] = 1'b1;
        @(negedge clk);
        check("t3 released in_ready", {127'd0, in_ready}, 128'd1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = '0;
        exp_count = exp_count + 16'd1;
        check("t3 out_valid5", {127'd0, out_valid[5]}, 128'd1);
        check("t3 ch5", {112'd0, chan(5)}, 128'h1234);
        check("t3 accept_count", {112'd0, accept_count}, 128'd2);

        // 4. drain, then back-to-back fill of all eight channels
        out_ready = 8'hFF;
        @(posedge clk);
        #1;
        out_ready = '0;
        check("t4 drained", {120'd0, out_valid}, 128'd0);
        start = cycles;
        for (int k = 0; k < 8; k++) send(3'(k), 16'h1000 + 16'(k));
        check("t4 cycles", 128'(cycles - start), 128'd8);
        check("t4 out_valid", {120'd0, out_valid}, 128'hFF);
        for (int k = 0; k < 8; k++)
            check($sformatf("t4 ch%0d", k), {112'd0, chan(k)}, {112'd0, 16'h1000 + 16'(k)});
        check("t4 accept_count", {112'd0, accept_count}, 128'd10);
        in_sel   = 3'd3;
        in_data  = 16'h9999;
        in_valid = 1'b1;
        @(negedge clk);
        check("t4 9th in_ready", {127'd0, in_ready}, 128'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;

        // 6. reset with all channels full, then a normal accept
        do_reset();
        check_reset_state();
        send(3'd2, 16'hA5A5);
        check("t6 out_valid", {120'd0, out_valid}, 128'h04);
        check("t6 ch2", {112'd0, chan(2)}, 128'hA5A5);
        check("t6 accept_count", {112'd0, accept_count}, 128'd1);

        // 5. sustained throughput and counter wrap (65536 accepts since reset)
        out_ready = 8'hFF;
        start = cycles;
        for (int i = 1; i < 65536; i++) begin
            send(3'($urandom_range(0, 7)), 16'(i));
            if (i == 65534)
                check("t5 count at FFFF", {112'd0, accept_count}, 128'hFFFF);
        end
        check("t5 throughput", 128'(cycles - start), 128'd65535);
        check("t5 accept_count wrap", {112'd0, accept_count}, {112'd0, exp_count});
        check("t5 accept_count zero", {112'd0, accept_count}, 128'd0);
        repeat (2) @(posedge clk);
        #1;
        check("t5 all drained", {120'd0, out_valid}, 128'd0);
        begin
            int left = 0;
            for (int k = 0; k < 8; k++) left += exp_q[k].size();
            check("t5 scoreboard empty", 128'(left), 128'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
